// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 constants: exception codes, register indices, handler vector and mode encoding.
// Also holds the victim-PC to EPC alignment helper used when an exception is taken.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // SR.IM and Cause.IP share the same bit position
  localparam int IM_LSB = 10;

  typedef enum logic {
    MODE_USER    = 1'b0,
    MODE_HANDLER = 1'b1
  } mode_e;

  // A delay-slot victim restarts at its branch, one word earlier
  function automatic logic [31:0] victim_epc(input logic [31:0] vpc, input logic bd);
    logic [31:0] pc;
    pc = bd ? (vpc - 32'd4) : vpc;
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage <-> CP0 signal bundle: mtc0/mfc0 access, victim info, interrupt lines, eret, Req/EPC.
// master = pipeline side, slave = CP0 block.
interface cp0_exc_ctrl_if #(
  parameter int HW_INT_W = 6
);
  logic                WE;
  logic [4:0]          CP0Addr;
  logic [31:0]         CP0In;
  logic [31:0]         CP0Out;
  logic [31:0]         VPC;
  logic                BDIn;
  logic [4:0]          ExcCodeIn;
  logic [HW_INT_W-1:0] HWInt;
  logic                EXLClr;
  logic [31:0]         EPCOut;
  logic                Req;

  modport master (
    output WE, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  WE, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );
endinterface

// File: rtl/cp0_int_arb.sv
// Combinational interrupt/exception arbiter: masked interrupt request, pipeline exception request,
// and the code to latch into Cause (interrupt wins). Zero latency, no state.
module cp0_int_arb
  import cp0_exc_ctrl_pkg::*;
#(
  parameter int HW_INT_W = 6
) (
  input  logic [HW_INT_W-1:0] hwint,
  input  logic [HW_INT_W-1:0] im,
  input  logic                ie,
  input  logic                exl,
  input  logic [4:0]          exc_code_in,
  output logic                int_req,
  output logic                exc_req,
  output logic [4:0]          exc_code
);

  assign int_req  = (|(hwint & im)) & ie & ~exl;
  assign exc_req  = (exc_code_in != EXC_INT) & ~exl;
  assign exc_code = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file (SR/Cause/EPC/PRId) with exception/interrupt request generation beside M.
// Req and EPCOut are combinational; register updates take effect on the next clk edge.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h2023_0007,
  parameter int          HW_INT_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  cp0_exc_ctrl_if.slave  cp0
);

  mode_e               mode_q, mode_d;
  logic [HW_INT_W-1:0] im_q;
  logic                ie_q;
  logic [HW_INT_W-1:0] ip_q;
  logic                bd_q;
  logic [4:0]          exc_code_q;
  logic [31:0]         epc_q;

  logic                exl;
  logic                int_req, exc_req, req;
  logic [4:0]          sel_code;
  logic                wr_sr, wr_epc;
  logic [31:0]         sr_word, cause_word;

  assign exl = (mode_q == MODE_HANDLER);

  cp0_int_arb #(.HW_INT_W(HW_INT_W)) u_arb (
    .hwint       (cp0.HWInt),
    .im          (im_q),
    .ie          (ie_q),
    .exl         (exl),
    .exc_code_in (cp0.ExcCodeIn),
    .int_req     (int_req),
    .exc_req     (exc_req),
    .exc_code    (sel_code)
  );

  // Gated by reset so Req drops the instant reset asserts, even with ExcCodeIn still set
  assign req    = (int_req | exc_req) & reset;
  assign wr_sr  = cp0.WE & (cp0.CP0Addr == CP0_SR)  & ~req;
  assign wr_epc = cp0.WE & (cp0.CP0Addr == CP0_EPC) & ~req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_USER;
    end else begin
      mode_q <= mode_d;
    end
  end

  // eret overrides an mtc0 that tries to set EXL in the same cycle
  always_comb begin
    mode_d = mode_q;
    if (req) begin
      mode_d = MODE_HANDLER;
    end else begin
      if (wr_sr) begin
        mode_d = cp0.CP0In[1] ? MODE_HANDLER : MODE_USER;
      end
      if (cp0.EXLClr) begin
        mode_d = MODE_USER;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= '0;
      ie_q       <= 1'b0;
      ip_q       <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= EXC_INT;
      epc_q      <= '0;
    end else begin
      ip_q <= cp0.HWInt;
      if (req) begin
        bd_q       <= cp0.BDIn;
        exc_code_q <= sel_code;
        epc_q      <= victim_epc(cp0.VPC, cp0.BDIn);
      end else begin
        if (wr_sr) begin
          im_q <= cp0.CP0In[IM_LSB +: HW_INT_W];
          ie_q <= cp0.CP0In[0];
        end
        if (wr_epc) begin
          epc_q <= cp0.CP0In;
        end
      end
    end
  end

  always_comb begin
    sr_word                       = '0;
    sr_word[IM_LSB +: HW_INT_W]   = im_q;
    sr_word[1]                    = exl;
    sr_word[0]                    = ie_q;
    cause_word                    = '0;
    cause_word[31]                = bd_q;
    cause_word[IM_LSB +: HW_INT_W] = ip_q;
    cause_word[6:2]               = exc_code_q;
  end

  always_comb begin
    case (cp0.CP0Addr)
      CP0_SR:    cp0.CP0Out = sr_word;
      CP0_CAUSE: cp0.CP0Out = cause_word;
      CP0_EPC:   cp0.CP0Out = epc_q;
      CP0_PRID:  cp0.CP0Out = PRID_VAL;
      default:   cp0.CP0Out = '0;
    endcase
  end

  // An eret issued alongside an mtc0 EPC must return to the new address
  assign cp0.EPCOut = !reset  ? 32'h0 :
                      wr_epc ? cp0.CP0In : epc_q;

  assign cp0.Req = req;

endmodule
